// File: rtl/l2_port_arbiter_pkg.sv
// Shared constants for the L2 port arbiter: FSM encoding, default widths, grant codes.
// Latency: none, constants only; backpressure: not applicable.
package l2_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT_I = 3'd1;
    localparam logic [2:0] GNT_D = 3'd2;
    localparam logic [2:0] REL_I = 3'd3;
    localparam logic [2:0] REL_D = 3'd4;

    localparam logic [1:0] GRANT_I = 2'b01;
    localparam logic [1:0] GRANT_D = 2'b10;
    localparam logic [1:0] GRANT_NONE = 2'b00;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Cache-side and L2-side handshake bundle of the L2 port arbiter.
// Latency: wires only; backpressure: requests are held by the caches until their ready pulse.
interface l2_port_arbiter_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic              i_r;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              d_r;
    logic              d_w;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ready;
    logic              l2_r;
    logic              l2_w;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_ready;
    logic [1:0]        grant;
    logic              busy;

    // Arbiter side
    modport slave (
        input  i_r, i_addr, d_r, d_w, d_addr, d_wdata, l2_ready,
        output i_ready, d_ready, l2_r, l2_w, l2_addr, l2_wdata, grant, busy
    );

    // Caches/L2 side
    modport master (
        output i_r, i_addr, d_r, d_w, d_addr, d_wdata, l2_ready,
        input  i_ready, d_ready, l2_r, l2_w, l2_addr, l2_wdata, grant, busy
    );
endinterface

// File: rtl/l2_port_arbiter_rr_arb2.sv
// Two-way combinational picker: pick=1 selects D, pick=0 selects I.
// Latency: combinational; backpressure: none, the caller decides when the pick is used.
module rr_arb2
    import l2_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       pick
);

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            // On conflict favour whoever did not win last time, unless D has fixed priority
            2'b11:   pick = rr_en ? (last == LAST_I) : 1'b1;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the L2 line port between I-cache and D-cache, one latched transaction at a time.
// Latency: l2_r/l2_w one cycle after request, ready one cycle after l2_ready; callers hold requests until ready.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter bit RR_EN  = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    l2_port_arbiter_if.slave  bus
);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_d;
    txn_t       txn_q;
    txn_t       txn_nxt;
    logic [1:0] req;
    logic       pick_d;
    logic       take;
    logic       gnt_st;

    assign req  = {bus.d_r | bus.d_w, bus.i_r};
    assign take = (state == IDLE) && (req != 2'b00);

    rr_arb2 u_pick (
        .req   (req),
        .last  (last_d),
        .rr_en (RR_EN),
        .pick  (pick_d)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = pick_d ? GNT_D : GNT_I;
            GNT_I:   if (bus.l2_ready) state_nxt = REL_I;
            GNT_D:   if (bus.l2_ready) state_nxt = REL_D;
            REL_I:   state_nxt = IDLE;
            REL_D:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once at grant; later changes by the requester are ignored
    always_comb begin
        txn_nxt = txn_q;
        if (take) begin
            if (pick_d) begin
                txn_nxt.wr    = bus.d_w;
                txn_nxt.addr  = bus.d_addr;
                txn_nxt.wdata = bus.d_wdata;
            end else begin
                txn_nxt.wr    = 1'b0;
                txn_nxt.addr  = bus.i_addr;
                txn_nxt.wdata = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= LAST_I;
            txn_q  <= '0;
        end else begin
            state <= state_nxt;
            txn_q <= txn_nxt;
            if (take) last_d <= pick_d;
        end
    end

    assign gnt_st       = (state == GNT_I) || (state == GNT_D);
    assign bus.l2_r     = gnt_st && !txn_q.wr;
    assign bus.l2_w     = gnt_st && txn_q.wr;
    assign bus.l2_addr  = txn_q.addr;
    assign bus.l2_wdata = txn_q.wdata;
    assign bus.i_ready  = (state == REL_I);
    assign bus.d_ready  = (state == REL_D);
    assign bus.busy     = (state != IDLE);

    always_comb begin
        bus.grant = GRANT_NONE;
        if ((state == GNT_I) || (state == REL_I)) bus.grant = GRANT_I;
        if ((state == GNT_D) || (state == REL_D)) bus.grant = GRANT_D;
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters driven in lockstep with identical stimulus.
// Latency: checks sampled 1 time unit after each rising edge; backpressure: requests held until ready.
module tb_l2_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    l2_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus1 ();
    l2_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus0 ();

    assign bus0.i_r      = bus1.i_r;
    assign bus0.i_addr   = bus1.i_addr;
    assign bus0.d_r      = bus1.d_r;
    assign bus0.d_w      = bus1.d_w;
    assign bus0.d_addr   = bus1.d_addr;
    assign bus0.d_wdata  = bus1.d_wdata;
    assign bus0.l2_ready = bus1.l2_ready;

    l2_port_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_EN(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    l2_port_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_EN(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One arbitrated transaction with l2_ready in the first grant cycle; g1/g0 are the expected winners
    task automatic txn(input string tag, input logic [1:0] g1, input logic [1:0] g0);
        step();
        chk({tag, "_grant_rr"}, bus1.grant, g1);
        chk({tag, "_grant_fix"}, bus0.grant, g0);
        chk({tag, "_rw_excl"}, (bus1.l2_r & bus1.l2_w) | (bus0.l2_r & bus0.l2_w), 1'b0);
        bus1.l2_ready = 1'b1;
        step();
        chk({tag, "_rdy_rr"}, {bus1.d_ready, bus1.i_ready}, g1);
        chk({tag, "_rdy_fix"}, {bus0.d_ready, bus0.i_ready}, g0);
        bus1.l2_ready = 1'b0;
        step();
        chk({tag, "_idle"}, {bus1.busy, bus0.busy}, 2'b00);
    endtask

    initial begin
        logic [127:0] pat;
        pat = {4{32'hA5A5_5A5A}};

        bus1.i_r = 1'b0;  bus1.i_addr = '0;
        bus1.d_r = 1'b0;  bus1.d_w = 1'b0;  bus1.d_addr = '0;  bus1.d_wdata = '0;
        bus1.l2_ready = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("rst_grant", {bus1.grant, bus0.grant}, 4'b0000);
        chk("rst_busy", {bus1.busy, bus0.busy}, 2'b00);
        chk("rst_rw", {bus1.l2_r, bus1.l2_w, bus0.l2_r, bus0.l2_w}, 4'b0000);
        chk("rst_ready", {bus1.i_ready, bus1.d_ready, bus0.i_ready, bus0.d_ready}, 4'b0000);
        chk("rst_addr", bus1.l2_addr, 32'h0);
        chk("rst_wdata", bus1.l2_wdata, 128'h0);
        rst = 1'b1;

        // Conflict from reset: RR gives D,I,D,I; fixed priority gives D every time
        bus1.i_r = 1'b1;  bus1.i_addr = 32'h2000_0040;
        bus1.d_r = 1'b1;  bus1.d_addr = 32'h1000_0080;
        txn("rr0", 2'b10, 2'b10);
        txn("rr1", 2'b01, 2'b10);
        txn("rr2", 2'b10, 2'b10);
        txn("rr3", 2'b01, 2'b10);
        bus1.i_r = 1'b0;
        bus1.d_r = 1'b0;

        // Single I read, l2_ready in the third cycle of l2_r
        bus1.i_r = 1'b1;  bus1.i_addr = 32'h2000_0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("iread_r%0d", k), {bus1.l2_r, bus0.l2_r}, 2'b11);
            chk($sformatf("iread_w%0d", k), {bus1.l2_w, bus0.l2_w}, 2'b00);
            chk($sformatf("iread_addr%0d", k), bus1.l2_addr, 32'h2000_0100);
            chk($sformatf("iread_drdy%0d", k), {bus1.d_ready, bus1.i_ready}, 2'b00);
            if (k == 3) bus1.l2_ready = 1'b1;
        end
        step();
        chk("iread_irdy", {bus1.i_ready, bus0.i_ready}, 2'b11);
        chk("iread_rel_rw", {bus1.l2_r, bus1.l2_w, bus1.d_ready}, 3'b000);
        bus1.i_r = 1'b0;
        bus1.l2_ready = 1'b0;
        step();
        chk("iread_done", {bus1.i_ready, bus1.busy, bus0.i_ready, bus0.busy}, 4'b0000);

        // D writeback with d_r also high: write wins, line held after d_wdata changes
        bus1.d_w = 1'b1;  bus1.d_r = 1'b1;
        bus1.d_addr = 32'h1000_0040;  bus1.d_wdata = pat;
        step();
        chk("wb_rw", {bus1.l2_r, bus1.l2_w, bus0.l2_r, bus0.l2_w}, 4'b0101);
        chk("wb_addr", bus1.l2_addr, 32'h1000_0040);
        chk("wb_wdata", bus1.l2_wdata, pat);
        bus1.d_wdata = '0;
        step();
        chk("wb_wdata_hold", bus0.l2_wdata, pat);
        bus1.l2_ready = 1'b1;
        step();
        chk("wb_drdy", {bus1.d_ready, bus1.i_ready, bus1.l2_w, bus0.d_ready}, 4'b1001);
        bus1.d_w = 1'b0;  bus1.d_r = 1'b0;  bus1.l2_ready = 1'b0;
        step();
        chk("wb_done", {bus1.d_ready, bus1.busy}, 2'b00);

        // Address changed and request withdrawn mid-grant
        bus1.i_r = 1'b1;  bus1.i_addr = 32'h3000_0200;
        step();
        chk("mid_addr0", bus1.l2_addr, 32'h3000_0200);
        bus1.i_addr = 32'hDEAD_BEE0;
        bus1.i_r = 1'b0;
        step();
        chk("mid_addr1", bus1.l2_addr, 32'h3000_0200);
        chk("mid_r", {bus1.l2_r, bus0.l2_r}, 2'b11);
        bus1.l2_ready = 1'b1;
        step();
        chk("mid_irdy", {bus1.i_ready, bus0.i_ready}, 2'b11);
        bus1.l2_ready = 1'b0;
        step();
        chk("mid_done", {bus1.busy, bus0.busy}, 2'b00);

        // Stray l2_ready while idle
        bus1.l2_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("idle_rdy%0d", k),
                {bus1.busy, bus1.grant, bus1.i_ready, bus1.d_ready, bus0.busy}, 6'b0);
        end
        bus1.l2_ready = 1'b0;

        // Asynchronous reset in GNT_D, then conflict must go to D again
        bus1.d_r = 1'b1;  bus1.d_addr = 32'h4000_0080;
        step();
        chk("arst_pre", {bus1.grant, bus0.grant}, 4'b1010);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out", {bus1.l2_r, bus1.grant, bus1.busy, bus0.l2_r, bus0.busy}, 6'b0);
        chk("arst_addr", bus1.l2_addr, 32'h0);
        bus1.d_r = 1'b0;
        step();
        rst = 1'b1;
        bus1.i_r = 1'b1;  bus1.d_r = 1'b1;
        txn("arst_conf", 2'b10, 2'b10);
        bus1.i_r = 1'b0;  bus1.d_r = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
